// File: rtl/eth_tx_frame_sequencer.sv
// eth_tx_frame_sequencer: emits preamble, SFD, 14-byte header and payload
// (optionally padded) one byte per out handshake, then holds an inter-frame gap.
// Ports: clk, rst_n; start/hdr request; pay_* payload in (valid/ready);
// out_* frame byte out (valid/ready) with crc_en/last flags; busy,
// frame_done, err_oversize status.
// Build option: define ETH_MIN_PAD_EN to pad short payloads to MIN_PAYLOAD.
module eth_tx_frame_sequencer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int MIN_PAYLOAD    = 46
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [111:0] hdr,
    input  logic [7:0]   pay_data,
    input  logic         pay_valid,
    input  logic         pay_last,
    output logic         pay_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_crc_en,
    output logic         out_last,
    output logic         busy,
    output logic         frame_done,
    output logic         err_oversize
);

`ifdef ETH_MIN_PAD_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_DRAIN, S_GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_DRAIN, S_GAP
    } state_t;
`endif

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
    localparam logic [10:0] HDR_LAST = 11'd13;
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [10:0] MAX_LAST = 11'(MAX_PAYLOAD - 1);
`ifdef ETH_MIN_PAD_EN
    localparam logic [10:0] MIN_LAST = 11'(MIN_PAYLOAD - 1);
`endif

    state_t         state_q, state_d;
    logic [10:0]    cnt_q, cnt_d;
    logic [10:0]    pay_cnt_q, pay_cnt_d;
    logic [111:0]   hdr_q, hdr_d;
    logic           hs;
    logic           at_max;
    logic           need_pad;

    assign hs     = out_valid && out_ready;
    assign at_max = (pay_cnt_q == MAX_LAST);
    assign busy   = (state_q != S_IDLE);

`ifdef ETH_MIN_PAD_EN
    // Count excludes the current byte, so "< MIN-1" means the total stays short.
    assign need_pad = pay_last && (pay_cnt_q < MIN_LAST);
`else
    assign need_pad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pay_cnt_d    = pay_cnt_q;
        hdr_d        = hdr_q;
        out_data     = 8'h00;
        out_valid    = 1'b0;
        out_crc_en   = 1'b0;
        out_last     = 1'b0;
        pay_ready    = 1'b0;
        frame_done   = 1'b0;
        err_oversize = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    hdr_d     = hdr;
                    cnt_d     = '0;
                    pay_cnt_d = '0;
                    state_d   = S_PRE;
                end
            end
            S_PRE: begin
                out_data  = 8'h55;
                out_valid = 1'b1;
                if (hs) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SFD;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            S_SFD: begin
                out_data  = 8'hD5;
                out_valid = 1'b1;
                if (hs) state_d = S_HDR;
            end
            S_HDR: begin
                out_data   = hdr_q[{cnt_q[3:0], 3'b000} +: 8];
                out_valid  = 1'b1;
                out_crc_en = 1'b1;
                if (hs) begin
                    if (cnt_q == HDR_LAST) begin
                        cnt_d   = '0;
                        state_d = S_PAY;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            S_PAY: begin
                out_data     = pay_data;
                out_valid    = pay_valid;
                out_crc_en   = 1'b1;
                pay_ready    = hs;
                out_last     = pay_valid && ((pay_last && !need_pad) || at_max);
                err_oversize = hs && at_max && !pay_last;
                if (hs) begin
                    pay_cnt_d = pay_cnt_q + 11'd1;
                    if (pay_last) begin
                        cnt_d = '0;
`ifdef ETH_MIN_PAD_EN
                        state_d = need_pad ? S_PAD : S_GAP;
`else
                        state_d = S_GAP;
`endif
                    end else if (at_max) begin
                        state_d = S_DRAIN;
                    end
                end
            end
`ifdef ETH_MIN_PAD_EN
            S_PAD: begin
                out_valid  = 1'b1;
                out_crc_en = 1'b1;
                out_last   = (pay_cnt_q == MIN_LAST);
                if (hs) begin
                    pay_cnt_d = pay_cnt_q + 11'd1;
                    if (pay_cnt_q == MIN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
`endif
            S_DRAIN: begin
                // Discard the rest of an oversize payload.
                pay_ready = 1'b1;
                if (pay_valid && pay_last) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (out_ready) begin
                    if (cnt_q == IFG_LAST) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pay_cnt_q <= '0;
            hdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_cnt_q <= pay_cnt_d;
            hdr_q     <= hdr_d;
        end
    end

endmodule
